// File: rtl/jk_excitation_driver.sv
// jk_excitation_driver: buffers desired next-state bits and drives J/K excitation for an external JK element
module jk_excitation_driver #(
    parameter int DEPTH         = 4,
    parameter bit DONT_CARE_VAL = 1'b0,
    parameter bit CHECK_EN      = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic       in_bit,
    output logic       in_ready,
    input  logic       q_fb,
    output logic       j,
    output logic       k,
    output logic       busy,
    output logic       err,
    output logic [7:0] count
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_t;
    state_t state, state_n;
    logic [AW:0] wptr, rptr;
    logic [DEPTH-1:0] mem;
    logic target, q_model, full, empty, push, pop, head, enc_q, j_n, k_n;
    assign empty    = wptr == rptr;
    assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign in_ready = !full;
    assign push     = in_valid && !full;
    assign pop      = !empty && state != DRIVE;
    assign head     = mem[rptr[AW-1:0]];
    assign busy     = state != IDLE || !empty;
    // a bit popped in CHECK is encoded against the value the model takes on this same edge
    assign enc_q    = state == CHECK ? target : q_model;
    always_comb begin
        state_n = pop ? DRIVE : state == DRIVE ? CHECK : IDLE;
        j_n     = pop && (enc_q ? DONT_CARE_VAL : head);
        k_n     = pop && (enc_q ? !head : DONT_CARE_VAL);
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_n;
    always_ff @(posedge clk)
        if (push) mem[wptr[AW-1:0]] <= in_bit;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr    <= '0;
            rptr    <= '0;
            target  <= 1'b0;
            q_model <= 1'b0;
            j       <= 1'b0;
            k       <= 1'b0;
            err     <= 1'b0;
            count   <= 8'd0;
        end else begin
            j <= j_n;
            k <= k_n;
            if (push) wptr <= wptr + (AW+1)'(1);
            if (pop) begin
                rptr   <= rptr + (AW+1)'(1);
                target <= head;
            end
            if (state == CHECK) begin
                err     <= err | (CHECK_EN && q_fb != target);
                q_model <= target;
                count   <= count + 8'd1;
            end
        end
    end
endmodule
